// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word fetches to instruction memory, buffers responses and hands them to decode.
// Define IFU_OPCODE_CHECK_EN to flag unrecognised opcodes on if_illegal; otherwise it is tied low.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_illegal,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [31:0]      redirect_target;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   in_use;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      pc_mem    [FIFO_DEPTH];
    logic [31:0]      instr_mem [FIFO_DEPTH];
    logic             req_fire;
    logic             rsp_seen;
    logic             redirect;
    logic             push;
    logic             pop;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign redirect        = redirect_valid && (state != BOOT);
    assign in_use          = {1'b0, outstanding} + {1'b0, fifo_count};

    // Requests stop once every buffer slot is spoken for, so responses can never overflow the FIFO.
    assign imem_req_valid  = (state == FETCH) && (in_use < DEPTH_LIM);
    assign imem_req_addr   = fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign rsp_seen        = imem_rsp_valid && (outstanding != '0);
    assign push            = rsp_seen && (state == FETCH) && !redirect;

    assign if_valid        = (fifo_count != '0);
    assign pop             = if_valid && if_ready && !redirect;
    assign if_pc           = pc_mem[rd_ptr];
    assign if_instr        = instr_mem[rd_ptr];

    always_comb begin
        outstanding_nxt = outstanding;
        if (req_fire)
            outstanding_nxt = outstanding_nxt + CNT_W'(1);
        if (rsp_seen)
            outstanding_nxt = outstanding_nxt - CNT_W'(1);
    end

    // After a redirect, outstanding doubles as the count of stale responses still to be discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
        end else begin
            case (state)
                BOOT: state <= FETCH;
                FETCH, DRAIN: begin
                    outstanding <= outstanding_nxt;
                    if (redirect) begin
                        fetch_pc <= redirect_target;
                        rsp_pc   <= redirect_target;
                        state    <= (outstanding_nxt != '0) ? DRAIN : FETCH;
                    end else begin
                        if (req_fire)
                            fetch_pc <= fetch_pc + 32'd4;
                        if (push)
                            rsp_pc <= rsp_pc + 32'd4;
                        if ((state == DRAIN) && (outstanding_nxt == '0))
                            state <= FETCH;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= rsp_pc;
                instr_mem[wr_ptr] <= imem_rsp_data;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef IFU_OPCODE_CHECK_EN
    logic ill_mem [FIFO_DEPTH];
    logic rsp_illegal;

    always_comb begin
        case (imem_rsp_data[6:0])
            7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
            7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: rsp_illegal = 1'b0;
            default:                           rsp_illegal = 1'b1;
        endcase
    end

    // The flag travels with its FIFO entry so it lines up with the presented instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                ill_mem[i] <= 1'b0;
        end else if (push) begin
            ill_mem[wr_ptr] <= rsp_illegal;
        end
    end

    assign if_illegal = ill_mem[rd_ptr];
`else
    assign if_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed corner cases, a vector table and randomized traffic
// checked against a transaction-level model (request stream, epoch-tagged responses, expected delivery queue).
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;

    typedef struct { logic [31:0] addr; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } word_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic ill; } pop_t;
    typedef struct { logic [31:0] target; logic [31:0] word; logic [31:0] exp_pc; logic exp_ill; } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_illegal;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    req_t        inflight[$];
    word_t       exp_q[$];
    pop_t        delivered[$];
    logic [31:0] req_log[$];
    logic [31:0] mem_over [logic [31:0]];
    logic [31:0] next_req_pc;
    int          epoch;
    int          rsp_pct;
    int          hs_count;
    int          dropped;
    int          total_pops;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_illegal     (if_illegal),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_over.exists(a))
            return mem_over[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic ref_illegal(input logic [31:0] w);
`ifdef IFU_OPCODE_CHECK_EN
        case (w[6:0])
            7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
            7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: return 1'b0;
            default:                           return 1'b1;
        endcase
`else
        return (w == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values();
        check_val("rst_req_valid", imem_req_valid, 0);
        check_val("rst_req_addr", imem_req_addr, RESET_PC);
        check_val("rst_if_valid", if_valid, 0);
        check_val("rst_if_pc", if_pc, 0);
        check_val("rst_if_instr", if_instr, 0);
        check_val("rst_if_illegal", if_illegal, 0);
    endtask

    // Asserts reset at the current time (may be mid-cycle), checks outputs, releases on a falling edge.
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        if_ready       = 1'b0;
        inflight.delete();
        exp_q.delete();
        next_req_pc = RESET_PC;
        epoch       = 0;
        #1;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_rsp();
        if (inflight.size() != 0 && $urandom_range(99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(inflight[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic checkOutput(input logic pend);
        logic stale;
        check_val("if_valid", if_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check_val("if_pc", if_pc, exp_q[0].pc);
            check_val("if_instr", if_instr, exp_q[0].instr);
            check_val("if_illegal", if_illegal, ref_illegal(exp_q[0].instr));
        end
        check_val("issue_limit", (inflight.size() + exp_q.size()) <= FIFO_DEPTH, 1);
        stale = 1'b0;
        foreach (inflight[i])
            if (inflight[i].epoch != epoch)
                stale = 1'b1;
        if (stale)
            check_val("no_req_while_draining", imem_req_valid, 0);
        if (pend) begin
            check_val("req_hold_valid", imem_req_valid, 1);
            check_val("req_hold_addr", imem_req_addr, next_req_pc);
        end
    endtask

    // One clock: predict the effects of the coming edge from the settled inputs, then check after it.
    task automatic tick();
        logic  hs;
        logic  pop;
        logic  pend;
        req_t  r;
        word_t w;
        pop_t  p;
        hs   = imem_req_valid && imem_req_ready;
        pop  = if_valid && if_ready && !redirect_valid;
        pend = imem_req_valid && !imem_req_ready && !redirect_valid;
        if (pop) begin
            p.pc = if_pc; p.instr = if_instr; p.ill = if_illegal;
            delivered.push_back(p);
            total_pops++;
            if (exp_q.size() != 0)
                void'(exp_q.pop_front());
        end
        if (imem_rsp_valid && inflight.size() != 0) begin
            r = inflight.pop_front();
            if (r.epoch == epoch && !redirect_valid) begin
                w.pc = r.addr; w.instr = imem_rsp_data;
                exp_q.push_back(w);
            end else begin
                dropped++;
            end
        end
        if (hs) begin
            check_val("req_addr", imem_req_addr, next_req_pc);
            r.addr = next_req_pc; r.epoch = epoch;
            inflight.push_back(r);
            req_log.push_back(imem_req_addr);
            next_req_pc = next_req_pc + 32'd4;
            hs_count++;
        end
        if (redirect_valid) begin
            epoch++;
            exp_q.delete();
            next_req_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        drive_rsp();
        checkOutput(pend);
    endtask

    task automatic applyStimulus();
        imem_req_ready = ($urandom_range(3) != 0);
        if_ready       = ($urandom_range(9) < 7);
        if ($urandom_range(99) < 3) begin
            redirect_valid = 1'b1;
            redirect_pc    = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(255));
        end
    endtask

    task automatic run_until_delivery(input int bound);
        int n;
        n = 0;
        while (delivered.size() == 0 && n < bound) begin
            tick();
            n++;
        end
        check_val("delivery_timeout", delivered.size() != 0, 1);
    endtask

    initial begin
        vec_t vecs[6];
        int   n;
        int   cnt;
        logic exp_ill;

        vecs[0] = '{32'h0000_0102, 32'h0000_007F, 32'h0000_0100, 1'b1};
        vecs[1] = '{32'h0000_0203, 32'h0000_0033, 32'h0000_0200, 1'b0};
        vecs[2] = '{32'h0000_0300, 32'hFFFF_FFEF, 32'h0000_0300, 1'b0};
        vecs[3] = '{32'hFFFF_FFFD, 32'h0000_0013, 32'hFFFF_FFFC, 1'b0};
        vecs[4] = '{32'h0000_0401, 32'h0000_0000, 32'h0000_0400, 1'b1};
        vecs[5] = '{32'h0000_0500, 32'h1234_5073, 32'h0000_0500, 1'b0};

        checks = 0; errors = 0; total_pops = 0; hs_count = 0; dropped = 0; rsp_pct = 100;
        #2;

        // Reset release: first instruction lands three edges after rst_n rises, then sequential PCs.
        do_reset();
        rsp_pct = 100; imem_req_ready = 1'b1; if_ready = 1'b1;
        n = 0;
        while (!if_valid && n < 20) begin tick(); n++; end
        check_val("first_valid_latency", n, 3);
        check_val("first_pc", if_pc, RESET_PC);
        delivered.delete();
        repeat (8) tick();
        check_val("boot_delivery_count", delivered.size() >= 3, 1);
        for (int i = 0; i < 3; i++)
            if (i < delivered.size())
                check_val("boot_pc_order", delivered[i].pc, RESET_PC + 32'(4 * i));

        // Decode stall: issue limit holds, head stays put, nothing lost afterwards.
        do_reset();
        rsp_pct = 100; imem_req_ready = 1'b1; if_ready = 1'b0; hs_count = 0;
        repeat (10) tick();
        check_val("stall_req_limit", hs_count <= 2, 1);
        check_val("stall_hold_pc", if_pc, RESET_PC);
        if_ready = 1'b1; delivered.delete();
        repeat (6) tick();
        check_val("stall_release_count", delivered.size() >= 2, 1);
        for (int i = 0; i < 2; i++)
            if (i < delivered.size())
                check_val("stall_release_pc", delivered[i].pc, RESET_PC + 32'(4 * i));

        // Redirect with two responses in flight: both dropped, fetch resumes at the aligned target.
        do_reset();
        rsp_pct = 0; imem_req_ready = 1'b1; if_ready = 1'b1;
        n = 0;
        while (inflight.size() < 2 && n < 20) begin tick(); n++; end
        check_val("drain_inflight", inflight.size(), 2);
        dropped = 0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        rsp_pct = 100; delivered.delete(); req_log.delete();
        run_until_delivery(30);
        check_val("drain_dropped", dropped, 2);
        if (req_log.size() != 0)
            check_val("drain_first_req", req_log[0], 32'h0000_0100);
        if (delivered.size() != 0)
            check_val("drain_first_pc", delivered[0].pc, 32'h0000_0100);

        // Memory not ready: request at 0x8 held, accepted exactly once.
        do_reset();
        rsp_pct = 100; imem_req_ready = 1'b1; if_ready = 1'b1;
        n = 0;
        while (next_req_pc != 32'h8 && n < 20) begin tick(); n++; end
        imem_req_ready = 1'b0;
        n = 0;
        while (!imem_req_valid && n < 20) begin tick(); n++; end
        check_val("busy_addr", imem_req_addr, 32'h8);
        repeat (5) begin
            tick();
            check_val("busy_valid_held", imem_req_valid, 1);
            check_val("busy_addr_held", imem_req_addr, 32'h8);
        end
        req_log.delete(); imem_req_ready = 1'b1;
        repeat (4) tick();
        cnt = 0;
        foreach (req_log[i]) if (req_log[i] == 32'h8) cnt++;
        check_val("busy_single_accept", cnt, 1);

        // Reset asserted in the middle of a drain.
        do_reset();
        rsp_pct = 0; imem_req_ready = 1'b1; if_ready = 1'b1;
        n = 0;
        while (inflight.size() < 2 && n < 20) begin tick(); n++; end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        tick();
        #2;
        do_reset();
        rsp_pct = 100; imem_req_ready = 1'b1; if_ready = 1'b1;
        delivered.delete(); req_log.delete();
        run_until_delivery(20);
        if (req_log.size() != 0)
            check_val("reset_restart_req", req_log[0], RESET_PC);
        if (delivered.size() != 0)
            check_val("reset_restart_pc", delivered[0].pc, RESET_PC);

        // Vector table: redirect alignment, address wrap and opcode flag.
        do_reset();
        rsp_pct = 100; imem_req_ready = 1'b1; if_ready = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            mem_over[vecs[i].exp_pc] = vecs[i].word;
`ifdef IFU_OPCODE_CHECK_EN
            exp_ill = vecs[i].exp_ill;
`else
            exp_ill = 1'b0;
`endif
            redirect_valid = 1'b1; redirect_pc = vecs[i].target;
            tick();
            delivered.delete();
            run_until_delivery(40);
            if (delivered.size() != 0) begin
                check_val("vec_pc", delivered[0].pc, vecs[i].exp_pc);
                check_val("vec_instr", delivered[0].instr, vecs[i].word);
                check_val("vec_illegal", delivered[0].ill, exp_ill);
            end
            repeat (4) tick();
        end

        // Randomized traffic against the model.
        do_reset();
        rsp_pct = 60;
        tick();
        total_pops = 0;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            tick();
        end
        check_val("random_progress", total_pops > 100, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage feeding the decode/control path.
- Drives word addresses to instruction memory through a valid/ready request channel and accepts in-order responses.
- Buffers fetched words in a small FIFO and presents {pc, instruction} to decode through a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing queued words and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, minimum 2; also caps outstanding requests.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response word valid; in order, no backpressure.
- imem_rsp_data  input  32  response instruction word.
- if_valid  output  1  instruction available to decode.
- if_ready  input  1  decode accepts instruction (low = stall).
- if_pc  output  32  PC of presented instruction.
- if_instr  output  32  presented instruction; opcode is bits [6:0].
- if_illegal  output  1  opcode-check flag (see Optional Feature).
- redirect_valid  input  1  branch/jump taken, single-cycle pulse.
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; state = BOOT.
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - if_valid = 0, if_pc = 0, if_instr = 0, if_illegal = 0.
- States:
  - BOOT -> FETCH after one cycle; no requests are issued in BOOT.
  - FETCH: imem_req_valid = 1 when outstanding + fifo_count < FIFO_DEPTH. imem_req_addr = fetch_pc. On a req handshake, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0) and outstanding++.
  - DRAIN: entered on redirect when in-flight responses remain. imem_req_valid = 0. Each response decrements discard and is dropped. Exit to FETCH in the cycle discard reaches 0; the first request from redirect_pc is issued the next cycle.
- Responses:
  - In FETCH, each response is pushed into the FIFO with its PC; the PC is tracked by a parallel PC queue or recomputed from fetch_pc.
  - outstanding-- on each response.
  - The FIFO cannot overflow, by the issue limit.
- Output side:
  - if_valid = FIFO non-empty. if_pc/if_instr are the head entry, registered (FIFO output).
  - Pop on if_valid & if_ready.
  - Outputs are stable while if_valid & !if_ready.
- Latency: response in cycle N -> if_valid in cycle N+1; no bypass.
- Redirect (highest priority, any state except BOOT):
  - FIFO is cleared; the same-cycle pop is suppressed.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - discard = outstanding + (req handshake this cycle) - (response this cycle).
  - Next state = DRAIN if discard != 0, else FETCH.
  - A redirect during DRAIN reloads fetch_pc and recomputes discard the same way.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Request issued while imem_req_ready = 0: valid and address are held until the handshake, except on redirect, which withdraws the request.

Optional Feature:
- Macro IFU_OPCODE_CHECK_EN.
- Defined: if_illegal is registered with the FIFO entry. It is 1 when the opcode is not one of 7'h03, 13, 17, 23, 33, 37, 63, 67, 6F, 73. The instruction is still delivered normally.
- Undefined: if_illegal is tied to 0 and no decode logic is present.

Test Plan:
- Reset release with memory ready and 1-cycle latency, if_ready = 1 -> requests to 0x0, 0x4, 0x8 on consecutive cycles. First if_valid appears 3 cycles after rst_n rises, with if_pc = 0x0, then 0x4, 0x8 back-to-back.
- if_ready held 0 for 10 cycles -> at most 2 requests issued. if_pc = 0x0 is held stable. After if_ready = 1, words 0x0 and 0x4 are delivered in order with none lost.
- Redirect to 0x0000_0102 with 2 responses in flight -> state DRAIN, 2 responses dropped. Next request is addr 0x100 and the first delivered if_pc = 0x100.
- imem_req_ready low for 5 cycles -> imem_req_valid = 1 and imem_req_addr = 0x8 are held constant; exactly one accept when ready rises.
- Redirect pulse while rst_n asserted mid-drain -> all outputs return to reset values immediately and fetching restarts from RESET_PC.
- IFU_OPCODE_CHECK_EN defined: response 32'h0000_007F -> if_illegal = 1. Response 32'h0000_0033 -> if_illegal = 0. Macro undefined -> if_illegal = 0 for both.
